// File: rtl/mme_pkg.sv
// rtl/mme_pkg.sv - shared FSM encoding and index-width helper for mme
package mme_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV_M   = 3'd1,
    CONV_ONE = 3'd2,
    SQR      = 3'd3,
    MUL      = 3'd4,
    FINAL    = 3'd5,
    DONE     = 3'd6
  } state_t;

  // Width of the exponent bit index; at least one bit so tiny N still builds.
  function automatic int idx_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mmm.sv
// rtl/mmm.sv - Montgomery multiplier y = a*b*2^-N mod n with start/ready handshake
module mmm #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rn,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] n,
  output logic         ready,
  output logic [N-1:0] y
);

  // Radix-2 steps folded per clock; widths not divisible by 8 fall back to one step.
  localparam int K     = (N % 8 == 0) ? 8 : 1;
  localparam int STEPS = N / K;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [N-1:0]  a_q, b_q;
  logic [N:0]    t, t_step;
  logic [N+1:0]  sum;
  logic [N-1:0]  t_red;
  logic [CW-1:0] cnt;

  // K interleaved add/halve steps; t stays below 2n because n < 2^(N-1).
  always_comb begin
    t_step = t;
    sum    = '0;
    for (int k = 0; k < K; k++) begin
      sum = {1'b0, t_step} + (a_q[k] ? {2'b0, b_q} : '0);
      if (sum[0]) sum = sum + {2'b0, n};
      t_step = sum[N+1:1];
    end
    t_red = N'((t_step >= {1'b0, n}) ? t_step - {1'b0, n} : t_step);
  end

  // Latch operands on start, iterate STEPS cycles, publish reduced result.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      a_q   <= '0;
      b_q   <= '0;
      t     <= '0;
      cnt   <= '0;
      y     <= '0;
      ready <= 1'b1;
    end else if (ready) begin
      if (start) begin
        a_q   <= a;
        b_q   <= b;
        t     <= '0;
        cnt   <= '0;
        ready <= 1'b0;
      end
    end else begin
      t   <= t_step;
      a_q <= a_q >> K;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(STEPS - 1)) begin
        y     <= t_red;
        ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mme.sv
// rtl/mme.sv - modular exponentiation y = m^e mod n over one mmm (option: MME_SKIP_LZ_EN)
module mme
  import mme_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rn,
  input  logic         start,
  input  logic [N-1:0] m,
  input  logic [N-1:0] e,
  input  logic [N-1:0] n,
  input  logic [N-1:0] r2,
  output logic         ready,
  output logic [N-1:0] y
);

  localparam int IW = idx_width(N);
  localparam logic [N-1:0] ONE = N'(1);

  state_t        state, state_next;
  logic          waiting;
  logic [N-1:0]  m_q, e_q, r2_q, xb, acc, y_int;
  logic [IW-1:0] idx;
  logic          op_state, op_done;
  logic          mmm_start, mmm_ready;
  logic [N-1:0]  mmm_a, mmm_b, mmm_y;

  mmm #(.N(N)) u_mmm (
    .clk   (clk),
    .rn    (rn),
    .start (mmm_start),
    .a     (mmm_a),
    .b     (mmm_b),
    .n     (n),
    .ready (mmm_ready),
    .y     (mmm_y)
  );

`ifdef MME_SKIP_LZ_EN
  logic [IW-1:0] first_idx;
  // Highest set bit of the exponent; squarings above it would only square R mod n.
  always_comb begin
    first_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (e_q[k]) first_idx = IW'(k);
    end
  end
`endif

  // Op states issue once, then wait for mmm; ready in the issue cycle is stale.
  assign op_state = (state == CONV_M) || (state == CONV_ONE) || (state == SQR) ||
                    (state == MUL) || (state == FINAL);
  assign op_done  = waiting && mmm_ready;

  // State register.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) state <= IDLE;
    else     state <= state_next;
  end

  // Next state (bit-index decision folded into capture edge), mmm operand mux and start pulse.
  always_comb begin
    state_next = state;
    mmm_a      = '0;
    mmm_b      = '0;
    mmm_start  = op_state && !waiting;
    case (state)
      IDLE:     if (start) state_next = CONV_M;
      CONV_M: begin
        mmm_a = m_q;
        mmm_b = r2_q;
        if (op_done) state_next = CONV_ONE;
      end
      CONV_ONE: begin
        mmm_a = ONE;
        mmm_b = r2_q;
`ifdef MME_SKIP_LZ_EN
        if (op_done) state_next = (e_q == '0) ? FINAL : SQR;
`else
        if (op_done) state_next = SQR;
`endif
      end
      SQR: begin
        mmm_a = acc;
        mmm_b = acc;
        if (op_done) state_next = e_q[idx] ? MUL : ((idx == '0) ? FINAL : SQR);
      end
      MUL: begin
        mmm_a = acc;
        mmm_b = xb;
        if (op_done) state_next = (idx == '0) ? FINAL : SQR;
      end
      FINAL: begin
        mmm_a = acc;
        mmm_b = ONE;
        if (op_done) state_next = DONE;
      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Operand latch, issue/wait tracking, result capture and bit-index stepping.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      m_q     <= '0;
      e_q     <= '0;
      r2_q    <= '0;
      xb      <= '0;
      acc     <= '0;
      y_int   <= '0;
      idx     <= '0;
      waiting <= 1'b0;
      y       <= '0;
      ready   <= 1'b1;
    end else begin
      if (state == IDLE && start) begin
        m_q   <= m;
        e_q   <= e;
        r2_q  <= r2;
        ready <= 1'b0;
      end
      if (op_state) waiting <= !op_done;
      if (op_done) begin
        case (state)
          CONV_M: xb <= mmm_y;
          CONV_ONE: begin
            acc <= mmm_y;
`ifdef MME_SKIP_LZ_EN
            idx <= first_idx;
`else
            idx <= IW'(N - 1);
`endif
          end
          SQR: begin
            acc <= mmm_y;
            if (!e_q[idx] && idx != '0) idx <= idx - 1'b1;
          end
          MUL: begin
            acc <= mmm_y;
            if (idx != '0) idx <= idx - 1'b1;
          end
          FINAL:   y_int <= mmm_y;
          default: ;
        endcase
      end
      if (state == DONE) begin
        y     <= y_int;
        ready <= 1'b1;
      end
    end
  end

endmodule
